// File: rtl/counter_cmd_scheduler_pkg.sv
// Shared types and constants for the button-driven counter command scheduler.
package counter_ctrl_pkg;

  localparam int N_REQ_DEF = 4;

  localparam int CMD_INC  = 0;
  localparam int CMD_DEC  = 1;
  localparam int CMD_CLR  = 2;
  localparam int CMD_LOAD = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } arb_state_e;

  // Wraps an index that may exceed n by at most n - 1.
  function automatic int wrap_idx(input int i, input int n);
    return (i >= n) ? i - n : i;
  endfunction

endpackage

// File: rtl/counter_cmd_scheduler_if.sv
// Command bus from the scheduler to the counter datapath.
// Handshake: a command transfers on a cycle where cmd_valid_o and cmd_ready_i are both 1;
// once cmd_valid_o rises, cmd_valid_o/cmd_id_o/grant_o hold steady until that transfer.
interface counter_cmd_scheduler_if
  import counter_ctrl_pkg::*;
#(
  parameter int N_REQ = N_REQ_DEF
);
  localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  logic             cmd_valid_o;
  logic             cmd_ready_i;
  logic [ID_W-1:0]  cmd_id_o;
  logic [N_REQ-1:0] grant_o;
  arb_state_e       arb_state;

  modport master (
    output cmd_valid_o,
    output cmd_id_o,
    output grant_o,
    output arb_state,
    input  cmd_ready_i
  );

  modport slave (
    input  cmd_valid_o,
    input  cmd_id_o,
    input  grant_o,
    input  arb_state,
    output cmd_ready_i
  );
endinterface

// File: rtl/counter_cmd_scheduler_hold_repeat_timer.sv
// Per-button event generator: one event on press, then auto-repeat events
// after HOLD_CYC cycles and every REPEAT_CYC cycles while held.
module hold_repeat_timer #(
  parameter int HOLD_CYC   = 50_000_000,
  parameter int REPEAT_CYC = 10_000_000,
  parameter int TMR_W      = $clog2(HOLD_CYC + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic req,
  input  logic repeat_en,
  output logic evt
);

  localparam logic [TMR_W-1:0] HOLD_TH   = TMR_W'(HOLD_CYC - 1);
  localparam logic [TMR_W-1:0] REPEAT_TH = TMR_W'(REPEAT_CYC - 1);

  logic             req_q;
  logic             phase;
  logic [TMR_W-1:0] tmr;
  logic             press;
  logic             rpt;
  logic [TMR_W-1:0] thr;

  assign press = req & ~req_q;
  assign thr   = phase ? REPEAT_TH : HOLD_TH;
  assign rpt   = req & repeat_en & ~press & (tmr == thr);
  assign evt   = press | rpt;

  // phase=0 waits for the long initial hold, phase=1 for the shorter repeat gap
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_q <= 1'b0;
      phase <= 1'b0;
      tmr   <= '0;
    end else begin
      req_q <= req;
      if (!req || press) begin
        tmr   <= '0;
        phase <= 1'b0;
      end else if (!repeat_en) begin
        tmr <= '0;
      end else if (rpt) begin
        tmr   <= '0;
        phase <= 1'b1;
      end else begin
        tmr <= tmr + TMR_W'(1);
      end
    end
  end

endmodule

// File: rtl/counter_cmd_scheduler.sv
// Collects press/auto-repeat events from N_REQ buttons, keeps one pending flag
// per button and hands the counter one command at a time in round-robin order.
module counter_cmd_scheduler
  import counter_ctrl_pkg::*;
#(
  parameter int N_REQ      = N_REQ_DEF,
  parameter int HOLD_CYC   = 50_000_000,
  parameter int REPEAT_CYC = 10_000_000,
  parameter int TMR_W      = $clog2(HOLD_CYC + 1)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_REQ-1:0]       req_i,
  input  logic [N_REQ-1:0]       repeat_en_i,
  output logic [N_REQ-1:0]       pending_o,
  output logic                   ovf_o,
  counter_cmd_scheduler_if.master cmd
);

  localparam int ID_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  arb_state_e       state, state_n;
  logic [N_REQ-1:0] evt, pend, pend_n, clr;
  logic [ID_W-1:0]  id_q, id_n, rr_ptr, rr_n, sel;
  logic             found, hs, ovf_n;
  int               idx;

  for (genvar g = 0; g < N_REQ; g++) begin : g_tmr
    hold_repeat_timer #(
      .HOLD_CYC  (HOLD_CYC),
      .REPEAT_CYC(REPEAT_CYC),
      .TMR_W     (TMR_W)
    ) u_tmr (
      .clk      (clk),
      .rst      (rst),
      .req      (req_i[g]),
      .repeat_en(repeat_en_i[g]),
      .evt      (evt[g])
    );
  end

  // First pending requester at or after rr_ptr, wrapping around.
  always_comb begin
    sel   = '0;
    found = 1'b0;
    idx   = 0;
    for (int j = 0; j < N_REQ; j++) begin
      idx = wrap_idx(int'(rr_ptr) + j, N_REQ);
      if (!found && pend[idx]) begin
        found = 1'b1;
        sel   = ID_W'(idx);
      end
    end
  end

  always_comb begin
    state_n = state;
    id_n    = id_q;
    rr_n    = rr_ptr;
    hs      = 1'b0;
    case (state)
      IDLE: begin
        if (found) begin
          state_n = OFFER;
          id_n    = sel;
        end
      end
      OFFER: begin
        if (cmd.cmd_ready_i) begin
          hs      = 1'b1;
          state_n = IDLE;
          rr_n    = ID_W'(wrap_idx(int'(id_q) + 1, N_REQ));
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // An event landing in its own handshake cycle re-arms the flag instead of overflowing.
  assign clr    = hs ? (N_REQ'(1) << id_q) : '0;
  assign pend_n = (pend & ~clr) | evt;
  assign ovf_n  = |(evt & pend & ~clr);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state  <= IDLE;
      id_q   <= '0;
      rr_ptr <= '0;
      pend   <= '0;
      ovf_o  <= 1'b0;
    end else begin
      state  <= state_n;
      id_q   <= id_n;
      rr_ptr <= rr_n;
      pend   <= pend_n;
      ovf_o  <= ovf_n;
    end
  end

  assign cmd.cmd_valid_o = (state == OFFER);
  assign cmd.cmd_id_o    = cmd.cmd_valid_o ? id_q : '0;
  assign cmd.grant_o     = cmd.cmd_valid_o ? (N_REQ'(1) << id_q) : '0;
  assign cmd.arb_state   = state;
  assign pending_o       = pend;

endmodule
